// File: rtl/regfile_wb_queue.sv
// rtl/regfile_wb_queue.sv - in-order writeback queue driving the tiny8 dual-write-port register file
//
// Purpose: accepts ALU and memory-stage writeback requests over valid/ready,
// holds them in an in-order circular queue and issues up to two register-file
// writes per cycle. Also reports a pending-register mask and forwards the
// youngest queued value for the register decode is reading.
//
// Ports:
//   clk, rst                     clock; asynchronous active-high reset
//   alu_valid/alu_ready          ALU writeback handshake
//   alu_reg, alu_data            ALU destination register and data
//   mem_valid/mem_ready          memory-stage writeback handshake
//   mem_reg, mem_data            memory-stage destination register and data
//   drain_en                     1 = writes may issue this cycle
//   load1, r1, in1               register-file write port 1
//   load2, r2, in2               register-file write port 2
//   src_reg                      register being read by decode
//   fwd_hit, fwd_data            youngest queued value for src_reg
//   pending                      bit i set while register i has a queued write
//   count                        occupied queue entries

module regfile_wb_queue #(
   parameter int DEPTH = 4,
   parameter int NREG  = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     alu_valid,
   output logic                     alu_ready,
   input  logic [1:0]               alu_reg,
   input  logic [7:0]               alu_data,
   input  logic                     mem_valid,
   output logic                     mem_ready,
   input  logic [1:0]               mem_reg,
   input  logic [7:0]               mem_data,
   input  logic                     drain_en,
   output logic                     load1,
   output logic [1:0]               r1,
   output logic [7:0]               in1,
   output logic                     load2,
   output logic [1:0]               r2,
   output logic [7:0]               in2,
   input  logic [1:0]               src_reg,
   output logic                     fwd_hit,
   output logic [7:0]               fwd_data,
   output logic [NREG-1:0]          pending,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic [AW-1:0] head1;
   logic [AW-1:0] mem_slot;
   logic [1:0]    ent_reg  [DEPTH];
   logic [7:0]    ent_data [DEPTH];
   logic          alu_acc;
   logic          mem_acc;
   logic [CW-1:0] enq_n;
   logic [CW-1:0] deq_n;

   // Readiness looks only at the registered count, so there is no
   // valid->ready path and a same-cycle drain earns no credit. MEM needs
   // room for two because it may be accepted alongside an ALU request.
   assign alu_ready = (count <= CW'(DEPTH - 1));
   assign mem_ready = (count <= CW'(DEPTH - 2));

   assign alu_acc  = alu_valid & alu_ready;
   assign mem_acc  = mem_valid & mem_ready;
   // When both are accepted the ALU entry is older and takes the tail slot.
   assign mem_slot = tail + AW'(alu_acc);
   assign enq_n    = CW'(alu_acc) + CW'(mem_acc);
   assign deq_n    = CW'(load1) + CW'(load2);

   // Issue: head on port 1, head+1 on port 2 unless both target the same
   // register, in which case head+1 waits a cycle so writes land in order.
   always_comb begin
      head1 = head + AW'(1);
      load1 = 1'b0;
      r1    = 2'd0;
      in1   = 8'd0;
      load2 = 1'b0;
      r2    = 2'd0;
      in2   = 8'd0;
      if (drain_en && count >= CW'(1)) begin
         load1 = 1'b1;
         r1    = ent_reg[head];
         in1   = ent_data[head];
      end
      if (drain_en && count >= CW'(2) && ent_reg[head1] != ent_reg[head]) begin
         load2 = 1'b1;
         r2    = ent_reg[head1];
         in2   = ent_data[head1];
      end
   end

   // Walk valid entries oldest to youngest; later matches overwrite earlier
   // ones so fwd_data ends up holding the youngest value. Entries issuing this
   // cycle are included since the register file does not hold them yet.
   always_comb begin
      logic [AW-1:0] idx;
      idx      = '0;
      fwd_hit  = 1'b0;
      fwd_data = 8'd0;
      pending  = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head + AW'(k);
         if (CW'(k) < count) begin
            pending[ent_reg[idx]] = 1'b1;
            if (ent_reg[idx] == src_reg) begin
               fwd_hit  = 1'b1;
               fwd_data = ent_data[idx];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + AW'(deq_n);
         tail  <= tail + AW'(enq_n);
         count <= count + enq_n - deq_n;
      end
   end

   // Entry storage needs no reset: occupancy is defined by count alone.
   always_ff @(posedge clk) begin
      if (!rst && alu_acc) begin
         ent_reg[tail]  <= alu_reg;
         ent_data[tail] <= alu_data;
      end
      if (!rst && mem_acc) begin
         ent_reg[mem_slot]  <= mem_reg;
         ent_data[mem_slot] <= mem_data;
      end
   end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// tb/tb_regfile_wb_queue.sv - scoreboard bench for regfile_wb_queue

module tb_regfile_wb_queue;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       alu_valid = 1'b0;
   logic       alu_ready;
   logic [1:0] alu_reg = 2'd0;
   logic [7:0] alu_data = 8'd0;
   logic       mem_valid = 1'b0;
   logic       mem_ready;
   logic [1:0] mem_reg = 2'd0;
   logic [7:0] mem_data = 8'd0;
   logic       drain_en = 1'b0;
   logic       load1;
   logic [1:0] r1;
   logic [7:0] in1;
   logic       load2;
   logic [1:0] r2;
   logic [7:0] in2;
   logic [1:0] src_reg = 2'd0;
   logic       fwd_hit;
   logic [7:0] fwd_data;
   logic [3:0] pending;
   logic [2:0] count;

   typedef struct packed {
      logic [1:0] r;
      logic [7:0] d;
   } wr_t;

   wr_t        exp_q[$];
   int         checks = 0;
   int         errors = 0;
   int         wr_count = 0;
   logic [7:0] model_rf  [4];
   logic [7:0] shadow_rf [4];

   regfile_wb_queue #(.DEPTH(4), .NREG(4)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_reg(mem_reg), .mem_data(mem_data),
      .drain_en(drain_en),
      .load1(load1), .r1(r1), .in1(in1),
      .load2(load2), .r2(r2), .in2(in2),
      .src_reg(src_reg), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
      .pending(pending), .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_port(input string name, input logic [1:0] r, input logic [7:0] d);
      wr_t e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s unexpected write reg=%0d data=0x%0h expected=none", name, r, d);
      end else begin
         e = exp_q.pop_front();
         chk({name, "_reg"}, 32'(r), 32'(e.r));
         chk({name, "_data"}, 32'(d), 32'(e.d));
      end
      shadow_rf[r] = d;
      wr_count++;
   endtask

   // Monitor: every issued write must be the next expected one, in order.
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         if (load1) check_port("port1", r1, in1);
         if (load2) begin
            check_port("port2", r2, in2);
            chk("port2_needs_port1", 32'(load1), 1);
            chk("port2_distinct_reg", 32'(r2 != r1), 1);
         end
      end
   end

   // Drive one request cycle; optionally record the expected writes.
   task automatic send(input logic av, input logic [1:0] ar, input logic [7:0] ad,
                       input logic mv, input logic [1:0] mr, input logic [7:0] md,
                       input bit push);
      alu_valid = av; alu_reg = ar; alu_data = ad;
      mem_valid = mv; mem_reg = mr; mem_data = md;
      if (av) chk("send_alu_ready", 32'(alu_ready), 1);
      if (mv) chk("send_mem_ready", 32'(mem_ready), 1);
      if (push) begin
         if (av) begin exp_q.push_back('{ar, ad}); model_rf[ar] = ad; end
         if (mv) begin exp_q.push_back('{mr, md}); model_rf[mr] = md; end
      end
      tick();
      alu_valid = 1'b0;
      mem_valid = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin
         model_rf[i]  = 8'd0;
         shadow_rf[i] = 8'd0;
      end
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_load1", 32'(load1), 0);
      chk("rst_load2", 32'(load2), 0);
      chk("rst_count", 32'(count), 0);
      chk("rst_pending", 32'(pending), 0);
      chk("rst_fwd_hit", 32'(fwd_hit), 0);
      chk("rst_fwd_data", 32'(fwd_data), 0);
      chk("rst_alu_ready", 32'(alu_ready), 1);
      chk("rst_mem_ready", 32'(mem_ready), 1);
      tick();
      rst = 1'b0;

      // 1: async reset with three entries queued
      tick();
      send(1'b1, 2'd0, 8'h01, 1'b1, 2'd1, 8'h02, 1'b0);
      send(1'b1, 2'd2, 8'h03, 1'b0, 2'd0, 8'h00, 1'b0);
      @(negedge clk);
      chk("t1_count3", 32'(count), 3);
      chk("t1_pending", 32'(pending), 'b0111);
      #2;
      rst = 1'b1;
      drain_en = 1'b1;
      #1;
      chk("t1_async_load1", 32'(load1), 0);
      chk("t1_async_load2", 32'(load2), 0);
      chk("t1_async_count", 32'(count), 0);
      chk("t1_async_pending", 32'(pending), 0);
      chk("t1_async_alu_ready", 32'(alu_ready), 1);
      chk("t1_async_mem_ready", 32'(mem_ready), 1);
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("t1_rel_load1", 32'(load1), 0);
      chk("t1_rel_count", 32'(count), 0);
      chk("t1_rel_pending", 32'(pending), 0);
      chk("t1_rel_alu_ready", 32'(alu_ready), 1);
      chk("t1_rel_mem_ready", 32'(mem_ready), 1);

      // 2: single ALU write, minimum latency
      tick();
      send(1'b1, 2'd2, 8'h5A, 1'b0, 2'd0, 8'h00, 1'b1);
      @(negedge clk);
      chk("t2_load1", 32'(load1), 1);
      chk("t2_r1", 32'(r1), 2);
      chk("t2_in1", 32'(in1), 'h5A);
      chk("t2_load2", 32'(load2), 0);
      chk("t2_pending", 32'(pending), 'b0100);
      tick();
      @(negedge clk);
      chk("t2_pending_after", 32'(pending), 0);
      chk("t2_count_after", 32'(count), 0);

      // 3: ALU and MEM to different registers issue together
      tick();
      send(1'b1, 2'd1, 8'h11, 1'b1, 2'd3, 8'h22, 1'b1);
      @(negedge clk);
      chk("t3_load1", 32'(load1), 1);
      chk("t3_r1", 32'(r1), 1);
      chk("t3_in1", 32'(in1), 'h11);
      chk("t3_load2", 32'(load2), 1);
      chk("t3_r2", 32'(r2), 3);
      chk("t3_in2", 32'(in2), 'h22);
      tick();
      @(negedge clk);
      chk("t3_count_after", 32'(count), 0);

      // 4: same-register pair serialises; forwarding shows youngest
      src_reg = 2'd0;
      tick();
      send(1'b1, 2'd0, 8'hAA, 1'b1, 2'd0, 8'hBB, 1'b1);
      @(negedge clk);
      chk("t4_c1_load1", 32'(load1), 1);
      chk("t4_c1_in1", 32'(in1), 'hAA);
      chk("t4_c1_load2", 32'(load2), 0);
      chk("t4_c1_fwd_hit", 32'(fwd_hit), 1);
      chk("t4_c1_fwd_data", 32'(fwd_data), 'hBB);
      chk("t4_c1_count", 32'(count), 2);
      tick();
      @(negedge clk);
      chk("t4_c2_load1", 32'(load1), 1);
      chk("t4_c2_in1", 32'(in1), 'hBB);
      chk("t4_c2_load2", 32'(load2), 0);
      chk("t4_c2_fwd_data", 32'(fwd_data), 'hBB);
      tick();
      @(negedge clk);
      chk("t4_c3_count", 32'(count), 0);
      chk("t4_c3_fwd_hit", 32'(fwd_hit), 0);
      chk("t4_c3_fwd_data", 32'(fwd_data), 0);

      // 5: fill with drain held, readies drop at 3 and 4, then drain
      drain_en = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         send(1'b1, 2'(i), 8'(8'h31 + i), 1'b0, 2'd0, 8'h00, 1'b1);
         @(negedge clk);
         chk("t5_count", 32'(count), 32'(i + 1));
         chk("t5_alu_ready", 32'(alu_ready), (i + 1 <= 3) ? 1 : 0);
         chk("t5_mem_ready", 32'(mem_ready), (i + 1 <= 2) ? 1 : 0);
         tick();
      end
      alu_valid = 1'b1; alu_reg = 2'd2; alu_data = 8'hEE;
      tick();
      alu_valid = 1'b0;
      @(negedge clk);
      chk("t5_full_no_accept", 32'(count), 4);
      chk("t5_full_no_load", 32'(load1), 0);
      tick();
      drain_en = 1'b1;
      @(negedge clk);
      chk("t5_d1_r1", 32'(r1), 0);
      chk("t5_d1_in2", 32'(in2), 'h32);
      tick();
      @(negedge clk);
      chk("t5_d2_r1", 32'(r1), 2);
      chk("t5_d2_in2", 32'(in2), 'h34);
      tick();
      @(negedge clk);
      chk("t5_count_after", 32'(count), 0);

      // 6: stream 12 ALU writes with alternating drain, pointers wrap
      tick();
      for (int k = 0; k < 12; k++) begin
         drain_en = 1'(k & 1);
         send(1'b1, 2'((k * 3) % 4), 8'(8'h40 + k), 1'b0, 2'd0, 8'h00, 1'b1);
      end
      drain_en = 1'b1;
      for (int n = 0; n < 10 && count != 3'd0; n++) tick();
      @(negedge clk);
      chk("t6_drained", 32'(count), 0);
      chk("t6_queue_empty", 32'(exp_q.size()), 0);
      chk("t6_write_total", 32'(wr_count), 21);
      for (int i = 0; i < 4; i++)
         chk("t6_rf_reg", 32'(shadow_rf[i]), 32'(model_rf[i]));
      chk("t6_rf_r0", 32'(shadow_rf[0]), 'h48);
      chk("t6_rf_r3", 32'(shadow_rf[3]), 'h49);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
